corrector_secded_pipe: RTL
==========================

// Module: corrector_secded_pipe
// PURPOSE
// - Parametrised SECDED (extended Hamming) decoder/corrector with valid/ready streaming and a 2-stage pipeline.
// - Generalises the fixed 8-bit/4-data-bit combinational corrector to any DATA_W.
// - Adds back-pressure, error classification, error-position output and optional error statistics.
// - Sits between the received-word source (switches/UART deserialiser) and the display/result logic.
// PARAMETERS
// - DATA_W  4   data bits per codeword (>=1).
// - P      (local) smallest P with 2**P >= DATA_W+P+1; Hamming parity bits (DATA_W=4 -> P=3).
// - N      (local) DATA_W+P+1; codeword width including overall parity (DATA_W=4 -> N=8).
// - CNT_W  16  width of each statistics counter.
// PORTS
// - clk            in   1        system clock, all logic on rising edge
// - rst_n          in   1        synchronous reset, active-low
// - in_valid       in   1        in_word valid
// - in_ready       out  1        block can accept in_word this cycle
// - in_word        in   N        received codeword
// - out_valid      out  1        out_* valid
// - out_ready      in   1        downstream accepts out_* this cycle
// - out_data       out  DATA_W   corrected data (raw data if uncorrectable)
// - out_err_single out  1        single error detected and corrected
// - out_err_double out  1        uncorrectable error detected
// - out_pos        out  P        flipped bit index on single error; 0 otherwise
// - clr_stats      in   1        synchronous clear of statistics counters
// - cnt_single     out  CNT_W    count of single errors delivered
// - cnt_double     out  CNT_W    count of uncorrectable words delivered
// BEHAVIOUR
// - Codeword layout:
//   - in_word[0] = overall even parity.
//   - in_word[i], i=1..N-1 = Hamming position i; parity at powers of 2.
//   - Data fills the remaining positions ascending, data[0] at lowest position.
// - Stage 1 registers word, syndrome S = XOR of indices i(1..N-1) with in_word[i]=1, and X = XOR of all N bits.
// - Stage 2 classification:
//   - X=0,S=0: clean, flags 0, pos 0.
//   - X=1,S=0: p0 flipped; single=1, pos 0, data unchanged.
//   - X=1,0<S<N: flip position S; single=1, pos=S.
//   - X=1,S>=N (shortened code): double=1, data raw, pos 0.
//   - X=0,S!=0: double=1, data raw, pos 0.
// - Latency 2 cycles (in handshake -> out_valid) with out_ready=1; throughput 1 word/cycle.
// - Handshake:
//   - s2_load = !s2_valid | out_ready.
//   - s1_load = !s1_valid | s2_load.
//   - in_ready = s1_load.
//   - out_* held stable while out_valid & !out_ready.
//   - Order preserved; no drop or duplication; max 2 words in flight.
// - Reset (rst_n=0 at clk edge): s1/s2 valid=0, out_valid=0, out_data/flags/pos=0, counters=0; in-flight words discarded.
// - in_ready is 1 in the first cycle after reset.
// CONFIGURATION
// - ERR_STATS_EN defined:
//   - cnt_single/cnt_double increment on out_valid&out_ready with the matching flag.
//   - Counters saturate at 2**CNT_W-1; clr_stats zeroes both (clr wins over increment in the same cycle).
// - ERR_STATS_EN undefined: counters not built; cnt_* tied 0; clr_stats ignored.
// TESTING (DATA_W=4, N=8, ERR_STATS_EN defined, CNT_W=4 unless noted)
// - Clean: in_word=8'hAA -> 2 cycles later out_data=4'b1011, single=0, double=0, pos=0.
// - Single: 8'h8A -> out_data=4'b1011, single=1, pos=5. 8'hAB -> out_data=4'b1011, single=1, pos=0.
// - Double: 8'hCA -> out_data=4'b1101 (raw), double=1, single=0, pos=0.
// - Back-pressure: out_ready=0, offer 3 words -> 2 accepted, then in_ready=0.
//   - Release out_ready -> words delivered in order, each stable while stalled.
// - Stats: 17 single-error words -> cnt_single=15 (saturated); clr_stats pulse -> 0 next cycle.
// - Reset mid-stream: rst_n=0 with 2 words in flight -> out_valid=0 and counters=0 next edge; none delivered.
// - DATA_W=8 (N=13): S=14 with X=1 -> double=1, data raw.

Source files
------------

// File: rtl/corrector_secded_pipe.sv
// SECDED (extended Hamming) corrector: stage 1 registers syndrome/parity, stage 2 classifies and corrects.
// Optional error statistics counters are built when ERR_STATS_EN is defined.
module corrector_secded_pipe #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    // Smallest P with 2**P >= DATA_W+P+1, in closed form.
    localparam int P      = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
    localparam int N      = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [P-1:0]      out_pos,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // Codeword position holding data bit j (non-power-of-two positions, ascending).
    function automatic int data_pos(input int j);
        int cnt;
        int r;
        cnt = 0;
        r   = 0;
        for (int i = 1; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == j) r = i;
                cnt++;
            end
        end
        return r;
    endfunction

    logic              s1_valid;
    logic [N-1:0]      s1_word;
    logic [P-1:0]      s1_syn;
    logic              s1_x;
    logic              s1_load;
    logic              s2_load;

    logic [P-1:0]      in_syn;
    logic              in_x;

    logic [N-1:0]      fix_word;
    logic [DATA_W-1:0] fix_data;
    logic              fix_single;
    logic              fix_double;
    logic [P-1:0]      fix_pos;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        in_syn = '0;
        in_x   = ^in_word;
        for (int i = 1; i < N; i++)
            if (in_word[i]) in_syn = in_syn ^ P'(i);
    end

    always_comb begin
        fix_word   = s1_word;
        fix_single = 1'b0;
        fix_double = 1'b0;
        fix_pos    = '0;
        if (s1_x) begin
            if (s1_syn == '0) begin
                fix_single = 1'b1;
            end else if (int'(s1_syn) < N) begin
                fix_single = 1'b1;
                fix_pos    = s1_syn;
                fix_word   = s1_word ^ ({{(N-1){1'b0}}, 1'b1} << s1_syn);
            end else begin
                // Syndrome points past the shortened code: treat as uncorrectable.
                fix_double = 1'b1;
            end
        end else if (s1_syn != '0) begin
            fix_double = 1'b1;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign fix_data[j] = fix_word[data_pos(j)];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_word        <= '0;
            s1_syn         <= '0;
            s1_x           <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_single <= 1'b0;
            out_err_double <= 1'b0;
            out_pos        <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_word <= in_word;
                    s1_syn  <= in_syn;
                    s1_x    <= in_x;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data       <= fix_data;
                    out_err_single <= fix_single;
                    out_err_double <= fix_double;
                    out_pos        <= fix_pos;
                end
            end
        end
    end

`ifdef ERR_STATS_EN
    // Saturating counters of delivered words; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err_single && cnt_single != '1) cnt_single <= cnt_single + 1'b1;
            if (out_err_double && cnt_double != '1) cnt_double <= cnt_double + 1'b1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_stats;
    assign cnt_single = '0;
    assign cnt_double = '0;
`endif

endmodule
